// File: rtl/axi_uart_pkg.sv
// Shared definitions for the AXI-Lite UART register slaves.
// Holds AXI response codes, the register indices decoded from araddr[3:2],
// the bit positions inside the STATUS and RXDATA words, and the read-side
// FSM state encoding.
package axi_uart_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_OVERRUN_BIT   = 1;
  localparam int STAT_FULL_BIT      = 2;

  localparam int RXDATA_VALID_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/axi_lite_rx_reader.sv
// AXI-Lite read-only slave returning UART RX bytes and RX status.
// One read outstanding at a time; an RXDATA read of a non-empty FIFO pops
// exactly one byte.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   s_axi_araddr/arvalid/arready  AR channel (decode uses araddr[3:2])
//   s_axi_rdata/rresp/rvalid/rready R channel
//   fifo_rd_en                 1-cycle pop strobe to the RX FIFO
//   fifo_rd_data               FIFO head byte, valid the cycle after the pop
//   fifo_empty, fifo_full      RX FIFO flags
//   rx_overrun                 1-cycle pulse: UART dropped a byte
//   dbg_state_o                current FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. rvalid, once high, holds with stable rdata/rresp until rready;
// rvalid never depends combinationally on rready. arready is high exactly in
// IDLE, so the next AR is only accepted after the R handshake.
module axi_lite_rx_reader
  import axi_uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  fifo_rd_en,
  input  logic [7:0]            fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic                  rx_overrun,
  output state_t                dbg_state_o
);

  state_t                state_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  overrun_q;
  logic                  overrun_d;

  logic [1:0]            reg_idx;
  logic                  ar_hs;
  logic                  status_hs;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rxdata_word;
  logic                  unused_addr_bits;

  assign reg_idx          = s_axi_araddr[3:2];
  // Byte-offset bits (and any bits above the decode) carry no meaning here.
  assign unused_addr_bits = ^s_axi_araddr;

  assign ar_hs     = (state_q == ST_IDLE) && s_axi_arvalid;
  assign status_hs = ar_hs && (reg_idx == REG_STATUS);

  // Pop is issued in the AR handshake cycle so the byte is on fifo_rd_data
  // while the FSM sits in FETCH.
  assign fifo_rd_en = ar_hs && (reg_idx == REG_RXDATA) && !fifo_empty;

  // A new overrun in the same cycle as the STATUS clear must not be lost.
  assign overrun_d = rx_overrun | (overrun_q & ~status_hs);

  always_comb begin
    status_word = '0;
    status_word[STAT_NOT_EMPTY_BIT] = ~fifo_empty;
    status_word[STAT_OVERRUN_BIT]   = overrun_q;
    status_word[STAT_FULL_BIT]      = fifo_full;
  end

  always_comb begin
    rxdata_word = '0;
    rxdata_word[7:0]              = fifo_rd_data;
    rxdata_word[RXDATA_VALID_BIT] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (s_axi_arvalid) begin
            case (reg_idx)
              REG_RXDATA: begin
                if (!fifo_empty) begin
                  state_q <= ST_FETCH;
                end else begin
                  rdata_q  <= '0;
                  rresp_q  <= RESP_OKAY;
                  rvalid_q <= 1'b1;
                  state_q  <= ST_RESP;
                end
              end
              REG_STATUS: begin
                rdata_q  <= status_word;
                rresp_q  <= RESP_OKAY;
                rvalid_q <= 1'b1;
                state_q  <= ST_RESP;
              end
              default: begin
                rdata_q  <= '0;
                rresp_q  <= RESP_SLVERR;
                rvalid_q <= 1'b1;
                state_q  <= ST_RESP;
              end
            endcase
          end
        end
        ST_FETCH: begin
          rdata_q  <= rxdata_word;
          rresp_q  <= RESP_OKAY;
          rvalid_q <= 1'b1;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          rvalid_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_axi_arready = (state_q == ST_IDLE);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_lite_rx_reader.sv
module tb_axi_lite_rx_reader;
  import axi_uart_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_full = 1'b0;
  logic        rx_overrun = 1'b0;
  state_t      dbg_state;

  always #5 clk = ~clk;

  axi_lite_rx_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .rx_overrun    (rx_overrun),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- external RX FIFO (depth 8) ----------------
  localparam int DEPTH = 8;
  logic [7:0] fifo_q[$];
  logic       push_en = 1'b0;
  logic [7:0] push_byte = '0;

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    if (push_en && fifo_q.size() < DEPTH) fifo_q.push_back(push_byte);
    fifo_empty <= (fifo_q.size() == 0);
    fifo_full  <= (fifo_q.size() == DEPTH);
  end

  // ---------------- check bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Transaction-level view: at the AR handshake the answer is decided from
  // the register map, FIFO contents and the overrun flag; it must appear
  // 1 cycle later (2 when a byte is popped) and hold until rready.
  logic [33:0] exp_q[$];   // {rresp, rdata}
  bit          txn_open = 0;
  bit          ovf_m = 0;
  int          cyc = 0;
  int          resp_cyc = 0;
  int          hs_cyc = 0;
  int          pops = 0;
  int          last_lat = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_rresp = '0;

  initial forever begin : monitor
    bit          exp_ar, exp_rv, exp_pop;
    logic [1:0]  idx;
    int          cnt;
    logic [33:0] e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("reset_arready", s_axi_arready, 1);
      chk("reset_rvalid", s_axi_rvalid, 0);
      txn_open = 0;
      ovf_m    = 0;
      exp_q.delete();
    end else begin
      cnt     = fifo_q.size();
      idx     = s_axi_araddr[3:2];
      exp_ar  = !txn_open;
      exp_rv  = txn_open && (cyc >= resp_cyc);
      exp_pop = exp_ar && s_axi_arvalid && (idx == 2'd0) && (cnt > 0);
      chk("arready", s_axi_arready, exp_ar);
      chk("rvalid", s_axi_rvalid, exp_rv);
      chk("fifo_rd_en", fifo_rd_en, exp_pop);
      if (exp_rv && exp_q.size() > 0) begin
        chk("rdata", s_axi_rdata, exp_q[0][31:0]);
        chk("rresp", s_axi_rresp, exp_q[0][33:32]);
      end
      // observed activity, used for hand-computed checks
      if (fifo_rd_en) pops++;
      if (s_axi_arvalid && s_axi_arready) hs_cyc = cyc;
      if (s_axi_rvalid && s_axi_rready) begin
        last_lat   = cyc - hs_cyc;
        last_rdata = s_axi_rdata;
        last_rresp = s_axi_rresp;
      end
      // advance the model
      if (exp_ar && s_axi_arvalid) begin
        txn_open = 1;
        resp_cyc = cyc + 1;
        case (idx)
          2'd0: begin
            if (cnt > 0) begin
              e = {2'b00, 24'h000001, fifo_q[0]};
              resp_cyc = cyc + 2;
            end else begin
              e = 34'h0;
            end
          end
          2'd1: begin
            e = {2'b00, 29'b0, (cnt == DEPTH), ovf_m, (cnt > 0)};
            ovf_m = 0;
          end
          default: e = {2'b10, 32'h0};
        endcase
        exp_q.push_back(e);
      end else if (exp_rv && s_axi_rready) begin
        txn_open = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (rx_overrun) ovf_m = 1;
    end
  end

  // ---------------- driver ----------------
  bit bg_en = 0;
  int rready_mode = 2;   // 0 random, 1 held low, 2 held high

  task automatic step();
    @(posedge clk);
    #1;
    if (bg_en) begin
      rx_overrun = ($urandom_range(0, 15) == 0);
      push_en    = ($urandom_range(0, 2) == 0);
      push_byte  = 8'($urandom_range(0, 255));
    end else begin
      rx_overrun = 1'b0;
      push_en    = 1'b0;
    end
    case (rready_mode)
      0:       s_axi_rready = ($urandom_range(0, 3) != 0);
      1:       s_axi_rready = 1'b0;
      default: s_axi_rready = 1'b1;
    endcase
  endtask

  task automatic push(input logic [7:0] b);
    push_en   = 1'b1;
    push_byte = b;
    step();
  endtask

  task automatic do_read(input logic [3:0] addr, input int hold, input bit ovf_at_hs);
    int t;
    int saved;
    saved = rready_mode;
    if (hold > 0) begin
      rready_mode  = 1;
      s_axi_rready = 1'b0;
    end
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    if (ovf_at_hs) rx_overrun = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin step(); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready low for %0d cycles, expected high", t);
    end
    step();
    s_axi_arvalid = 1'b0;
    if (hold > 0) begin
      repeat (hold) step();
      rready_mode = saved;
    end
    t = 0;
    while (txn_open && t < 200) begin step(); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL r_timeout: response open for %0d cycles, expected closed", t);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", s_axi_rdata, 32'h0);
    chk("reset_rresp", s_axi_rresp, 32'h0);
    chk("reset_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    step();
    step();

    // STATUS with empty FIFO, no overrun
    do_read(4'h4, 0, 0);
    chk("status_empty_data", last_rdata, 32'h0);
    chk("status_empty_lat", last_lat, 1);

    // RXDATA on an empty FIFO: no pop, zeros
    p0 = pops;
    do_read(4'h0, 0, 0);
    chk("rx_empty_data", last_rdata, 32'h0);
    chk("rx_empty_resp", last_rresp, 32'h0);
    chk("rx_empty_lat", last_lat, 1);
    chk("rx_empty_pops", pops - p0, 0);

    // RXDATA with 0xA5 queued
    push(8'hA5);
    p0 = pops;
    do_read(4'h1, 0, 0);   // byte-offset bits ignored
    chk("rx_a5_data", last_rdata, 32'h0000_01A5);
    chk("rx_a5_lat", last_lat, 2);
    chk("rx_a5_pops", pops - p0, 1);

    // fill FIFO: 0x11, 0x22 ... 0x88
    for (int i = 1; i <= 8; i++) push(8'(i * 17));
    step();
    do_read(4'h4, 0, 0);
    chk("status_full", last_rdata, 32'h5);

    // overrun pulse, then read-to-clear
    rx_overrun = 1'b1;
    step();
    do_read(4'h4, 0, 0);
    chk("status_ovf_set", last_rdata, 32'h7);
    do_read(4'h4, 0, 0);
    chk("status_ovf_clr", last_rdata, 32'h5);

    // overrun on the AR-handshake cycle: set wins over the clear
    do_read(4'h4, 0, 1);
    chk("status_hs_ovf_a", last_rdata, 32'h5);
    do_read(4'h4, 0, 0);
    chk("status_hs_ovf_b", last_rdata, 32'h7);
    do_read(4'h4, 0, 0);
    chk("status_hs_ovf_c", last_rdata, 32'h5);

    // reserved registers: SLVERR, no side effects
    rx_overrun = 1'b1;
    step();
    p0 = pops;
    do_read(4'h8, 0, 0);
    chk("slverr8_data", last_rdata, 32'h0);
    chk("slverr8_resp", last_rresp, 32'h2);
    do_read(4'hC, 0, 0);
    chk("slverrC_resp", last_rresp, 32'h2);
    chk("slverr_pops", pops - p0, 0);
    chk("slverr_fifo", fifo_q.size(), 8);
    do_read(4'h4, 0, 0);
    chk("slverr_keeps_ovf", last_rdata, 32'h7);

    // back-pressure: rready low in RESP for several cycles
    p0 = pops;
    do_read(4'h0, 6, 0);
    chk("stall_data", last_rdata, 32'h0000_0111);
    chk("stall_pops", pops - p0, 1);

    // reset while in FETCH: popped byte 0x22 is lost
    s_axi_araddr  = 4'h0;
    s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    reset = 1'b1;
    #2;
    chk("fetch_rst_state", dbg_state, ST_IDLE);
    chk("fetch_rst_arready", s_axi_arready, 1);
    chk("fetch_rst_rvalid", s_axi_rvalid, 0);
    step();
    step();
    reset = 1'b0;
    step();
    do_read(4'h0, 0, 0);
    chk("after_rst_data", last_rdata, 32'h0000_0133);
    do_read(4'h4, 0, 0);
    chk("after_rst_status", last_rdata, 32'h1);

    // randomized traffic against the model
    bg_en       = 1;
    rready_mode = 0;
    repeat (300) begin
      repeat ($urandom_range(0, 3)) step();
      do_read(4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0, 0);
    end
    bg_en = 0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
